// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use detection, multi-cycle memory conflicts,
// UART freeze with turnaround hold, and deferred branch-mispredict flushes.
module hazard_ctrl #(
  parameter int REG_W     = 4,
  parameter int NUM_RD    = 2,
  parameter logic [REG_W-1:0] NULL_REG = {REG_W{1'b1}},
  parameter int MEM_LAT   = 1,
  parameter int UART_HOLD = 1,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*REG_W-1:0] rd_regs,
  input  logic [NUM_RD-1:0]       rd_used,
  input  logic [REG_W-1:0]        ex_wreg,
  input  logic                    ex_is_load,
  input  logic                    mem_req,
  input  logic                    uart_busy,
  input  logic                    branch_err,
  input  logic                    perf_clr,
  output logic                    pc_keep,
  output logic                    if_keep,
  output logic                    id_keep,
  output logic                    exe_keep,
  output logic                    if_clear,
  output logic                    id_clear,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [1:0]              dbgState
);

  // One counter serves both wait states; they are mutually exclusive.
  localparam int CW = $clog2(MEM_LAT + UART_HOLD + 1) + 1;
  localparam logic [CW-1:0] MEM_LOAD  = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] UART_LOAD = CW'(UART_HOLD);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    UART_WAIT = 2'd2
  } hzState;

  hzState        state, stateNext;
  logic [CW-1:0] waitCnt, waitCntNext;
  logic          brp, brpNext;
  logic          anyMatch, loadUse, freeze, br;

  always_comb begin
    anyMatch = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_used[i] && (rd_regs[i*REG_W +: REG_W] == ex_wreg)) anyMatch = 1'b1;
    end
  end

  assign loadUse = ex_is_load && (ex_wreg != NULL_REG) && anyMatch;
  // A hold count of zero releases the pipeline in the first cycle uart_busy is low.
  assign freeze  = uart_busy || ((state == UART_WAIT) && (waitCnt != '0));
  assign br      = branch_err || brp;
  assign dbgState = state;

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    if (uart_busy) begin
      stateNext   = UART_WAIT;
      waitCntNext = UART_LOAD;
    end else if ((state == UART_WAIT) && (waitCnt != '0)) begin
      waitCntNext = waitCnt - CW'(1);
    end else if (state == MEM_WAIT) begin
      if (waitCnt == CW'(1)) begin
        stateNext   = RUN;
        waitCntNext = '0;
      end else begin
        waitCntNext = waitCnt - CW'(1);
      end
    end else begin
      // RUN, or a UART_WAIT whose hold has expired, behaves as RUN.
      stateNext   = RUN;
      waitCntNext = '0;
      if (mem_req && (MEM_LAT > 1)) begin
        stateNext   = MEM_WAIT;
        waitCntNext = MEM_LOAD;
      end
    end
  end

  always_comb begin
    brpNext = 1'b0;
    if (freeze) brpNext = brp || branch_err;
  end

  always_comb begin
    pc_keep  = 1'b0;
    if_keep  = 1'b0;
    id_keep  = 1'b0;
    exe_keep = 1'b0;
    if_clear = 1'b0;
    id_clear = 1'b0;
    if (rst) begin
      pc_keep = 1'b0;
    end else if (freeze) begin
      pc_keep  = 1'b1;
      if_keep  = 1'b1;
      id_keep  = 1'b1;
      exe_keep = 1'b1;
    end else if ((state == MEM_WAIT) || mem_req) begin
      pc_keep = 1'b1;
      if (loadUse && !br) begin
        if_keep  = 1'b1;
        id_clear = 1'b1;
      end else begin
        if_clear = 1'b1;
      end
    end else if (br) begin
      if_clear = 1'b1;
    end else if (loadUse) begin
      pc_keep  = 1'b1;
      if_keep  = 1'b1;
      id_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      waitCnt   <= '0;
      brp       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      brp     <= brpNext;
      if (perf_clr) begin
        stall_cnt <= '0;
      end else if (pc_keep && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
